// File: rtl/level_map_gen.sv
// level_map_gen: LFSR-driven COLS x ROWS safe-tile map generator with registered pixel lookup.
// Build macro SAFE_BORDER_EN forces every border tile safe during generation.
module level_map_gen #(
    parameter int SCREEN_WIDTH  = 400,
    parameter int SCREEN_HEIGHT = 600,
    parameter int BLOCK_SIZE    = 20,
    parameter int RAND_WIDTH    = 8,
    parameter int P_NONE        = 64,
    parameter int P_SOME        = 77,
    parameter int P_UPLEFT      = 128,
    parameter int P_ALL         = 26
) (
    input  logic                                  clk,
    input  logic                                  arst_n,
    input  logic                                  i_regenerate,
    input  logic [15:0]                           i_seed,
    output logic                                  o_busy,
    output logic                                  o_done,
    input  logic [$clog2(SCREEN_WIDTH)-1:0]       i_x,
    input  logic [$clog2(SCREEN_HEIGHT)-1:0]      i_y,
    output logic                                  o_is_safe,
    output logic [$clog2(SCREEN_WIDTH/BLOCK_SIZE*(SCREEN_HEIGHT/BLOCK_SIZE)+1)-1:0] o_safe_count
);
    localparam int COLS = SCREEN_WIDTH / BLOCK_SIZE;
    localparam int ROWS = SCREEN_HEIGHT / BLOCK_SIZE;
    localparam int N    = COLS * ROWS;
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int XW   = $clog2(SCREEN_WIDTH);
    localparam int YW   = $clog2(SCREEN_HEIGHT);
    localparam int SCW  = $clog2(N + 1);
    localparam int TW   = RAND_WIDTH + 1;

    localparam logic [15:0] LFSR_RESET = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    typedef enum logic {IDLE, GEN} state_e;

    state_e          state_q;
    logic [CW-1:0]   col_q;
    logic [RW-1:0]   row_q;
    logic [15:0]     lfsr_q;
    logic [COLS-1:0] map_q [ROWS];
    logic [SCW-1:0]  cnt_q;
    logic            done_q;
    logic            safe_q;

    logic            nb_up, nb_left, nb_ul, border, tile_d, last_tile, lookup_d;
    logic [RW-1:0]   up_row;
    logic [CW-1:0]   left_col;
    logic [TW-1:0]   thr;
    logic [15:0]     lfsr_d;
    logic [XW-1:0]   lk_col;
    logic [YW-1:0]   lk_row;

    assign up_row    = row_q - 1'b1;
    assign left_col  = col_q - 1'b1;
    assign nb_up     = (row_q != '0) && map_q[up_row][col_q];
    assign nb_left   = (col_q != '0) && map_q[row_q][left_col];
    assign nb_ul     = (row_q != '0) && (col_q != '0) && map_q[up_row][left_col];
    assign last_tile = (col_q == CW'(COLS - 1)) && (row_q == RW'(ROWS - 1));
    assign lfsr_d    = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);

`ifdef SAFE_BORDER_EN
    assign border = (row_q == '0) || (row_q == RW'(ROWS - 1)) ||
                    (col_q == '0) || (col_q == CW'(COLS - 1));
`else
    assign border = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        thr = TW'(P_SOME);
        if (nb_up && nb_left && nb_ul)
            thr = TW'(P_ALL);
        else if (nb_up && nb_left)
            thr = TW'(P_UPLEFT);
        else if (!nb_up && !nb_left && !nb_ul)
            thr = TW'(P_NONE);
        tile_d = border || ({1'b0, lfsr_q[RAND_WIDTH-1:0]} < thr);
    end

    assign lk_col = i_x / XW'(BLOCK_SIZE);
    assign lk_row = i_y / YW'(BLOCK_SIZE);

    always_comb begin
        lookup_d = 1'b0;
        if ((32'(lk_col) < COLS) && (32'(lk_row) < ROWS) && (state_q == IDLE))
            lookup_d = map_q[RW'(lk_row)][CW'(lk_col)];
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            lfsr_q  <= LFSR_RESET;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            safe_q  <= 1'b0;
            // NOTE: the map is flop-based, so it can be cleared here; a RAM-backed map could not be.
            for (int r = 0; r < ROWS; r++)
                map_q[r] <= '0;
        end else begin
            done_q <= 1'b0;
            safe_q <= lookup_d;
            if (i_regenerate) begin
                state_q <= GEN;
                col_q   <= '0;
                row_q   <= '0;
                cnt_q   <= '0;
                lfsr_q  <= (i_seed == 16'h0) ? LFSR_RESET : i_seed;
            end else if (state_q == GEN) begin
                map_q[row_q][col_q] <= tile_d;
                cnt_q  <= cnt_q + SCW'(tile_d);
                lfsr_q <= lfsr_d;
                if (last_tile) begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                    col_q   <= '0;
                    row_q   <= '0;
                end else if (col_q == CW'(COLS - 1)) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    assign o_busy       = (state_q == GEN);
    assign o_done       = done_q;
    assign o_is_safe    = safe_q;
    assign o_safe_count = cnt_q;

endmodule

// File: tb/tb_level_map_gen.sv
// tb_level_map_gen: three 4x3 instances (default, all-256 and all-0 thresholds) checked against a tile-map model.
module tb_level_map_gen;
    localparam int SW = 80, SH = 60, BS = 20;
    localparam int COLS = 4, ROWS = 3, N = 12;

    logic        clk = 1'b0, arst_n = 1'b0, regen = 1'b0;
    logic [15:0] seed = 16'h0;
    logic [6:0]  x = '0;
    logic [5:0]  y = '0;
    logic        busy_d, done_d, safe_d, busy_h, done_h, safe_h, busy_l, done_l, safe_l;
    logic [3:0]  cnt_d, cnt_h, cnt_l;
    logic [N-1:0] exp_d, exp_h, exp_l;
    int tests_run = 0, tests_failed = 0;

    always #5 clk = ~clk;

    level_map_gen #(.SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH), .BLOCK_SIZE(BS)) dut_def (
        .clk(clk), .arst_n(arst_n), .i_regenerate(regen), .i_seed(seed), .o_busy(busy_d), .o_done(done_d),
        .i_x(x), .i_y(y), .o_is_safe(safe_d), .o_safe_count(cnt_d));
    level_map_gen #(.SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH), .BLOCK_SIZE(BS),
                    .P_NONE(256), .P_SOME(256), .P_UPLEFT(256), .P_ALL(256)) dut_hi (
        .clk(clk), .arst_n(arst_n), .i_regenerate(regen), .i_seed(seed), .o_busy(busy_h), .o_done(done_h),
        .i_x(x), .i_y(y), .o_is_safe(safe_h), .o_safe_count(cnt_h));
    level_map_gen #(.SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH), .BLOCK_SIZE(BS),
                    .P_NONE(0), .P_SOME(0), .P_UPLEFT(0), .P_ALL(0)) dut_lo (
        .clk(clk), .arst_n(arst_n), .i_regenerate(regen), .i_seed(seed), .o_busy(busy_l), .o_done(done_l),
        .i_x(x), .i_y(y), .o_is_safe(safe_l), .o_safe_count(cnt_l));

    // Reference: walk the tiles in raster order, choosing a threshold from already-generated neighbours.
    function automatic logic [N-1:0] model(input logic [15:0] s, input int pn, input int ps,
                                           input int pu, input int pa);
        int lfsr, p, r, c;
        bit up, lf, ul;
        logic [N-1:0] m;
        lfsr = (s == 16'h0) ? 'hACE1 : int'(s);
        m = '0;
        for (int k = 0; k < N; k++) begin
            r  = k / COLS;
            c  = k % COLS;
            up = (r > 0) ? m[k - COLS] : 1'b0;
            lf = (c > 0) ? m[k - 1] : 1'b0;
            ul = (r > 0 && c > 0) ? m[k - COLS - 1] : 1'b0;
            if (up && lf && ul)          p = pa;
            else if (up && lf)           p = pu;
            else if (!up && !lf && !ul)  p = pn;
            else                         p = ps;
            m[k] = (lfsr % 256) < p;
`ifdef SAFE_BORDER_EN
            if (r == 0 || r == ROWS - 1 || c == 0 || c == COLS - 1) m[k] = 1'b1;
`endif
            if (lfsr % 2 == 1) lfsr = (lfsr / 2) ^ 'hB400;
            else               lfsr = lfsr / 2;
        end
        return m;
    endfunction

    task automatic set_expect(input logic [15:0] s);
        exp_d = model(s, 64, 77, 128, 26);
        exp_h = model(s, 256, 256, 256, 256);
        exp_l = model(s, 0, 0, 0, 0);
    endtask

    task automatic pulse(input logic [15:0] s);
        seed  = s;
        regen = 1'b1;
        @(negedge clk);
        regen = 1'b0;
    endtask

    // Entered on the negedge after the regenerate edge; expects 12 busy cycles, then one done pulse.
    task automatic wait_done(input string tag);
        int busy_cycles = 0, early_done = 0;
        while (busy_d && busy_cycles < 100) begin
            busy_cycles++;
            if (done_d || done_h || done_l) early_done++;
            @(negedge clk);
        end
        tests_run++;
        if (busy_cycles !== N) begin
            tests_failed++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", tag, busy_cycles, N);
        end
        tests_run++;
        if (early_done !== 0) begin
            tests_failed++;
            $display("FAIL %s done_while_busy: got %0d expected 0", tag, early_done);
        end
        tests_run++;
        if ({done_d, done_h, done_l, busy_h, busy_l} !== 5'b11100) begin
            tests_failed++;
            $display("FAIL %s done_pulse: got %b expected 11100", tag, {done_d, done_h, done_l, busy_h, busy_l});
        end
        @(negedge clk);
        tests_run++;
        if ({done_d, done_h, done_l} !== 3'b000) begin
            tests_failed++;
            $display("FAIL %s done_clear: got %b expected 000", tag, {done_d, done_h, done_l});
        end
    endtask

    task automatic check_counts(input string tag);
        tests_run++;
        if ({cnt_d, cnt_h, cnt_l} !== {4'($countones(exp_d)), 4'($countones(exp_h)), 4'($countones(exp_l))}) begin
            tests_failed++;
            $display("FAIL %s safe_count: got %0d/%0d/%0d expected %0d/%0d/%0d", tag, cnt_d, cnt_h, cnt_l,
                     $countones(exp_d), $countones(exp_h), $countones(exp_l));
        end
    endtask

    // Random pixel inside each tile; result is compared one cycle after the coordinate is presented.
    task automatic check_maps(input string tag);
        for (int k = 0; k < N; k++) begin
            x = 7'((k % COLS) * BS + int'($urandom_range(0, BS - 1)));
            y = 6'((k / COLS) * BS + int'($urandom_range(0, BS - 1)));
            @(negedge clk);
            tests_run++;
            if ({safe_d, safe_h, safe_l} !== {exp_d[k], exp_h[k], exp_l[k]}) begin
                tests_failed++;
                $display("FAIL %s tile%0d (%0d,%0d): got %b expected %b", tag, k, x, y,
                         {safe_d, safe_h, safe_l}, {exp_d[k], exp_h[k], exp_l[k]});
            end
        end
    endtask

    task automatic run_gen(input logic [15:0] s, input string tag);
        set_expect(s);
        pulse(s);
        wait_done(tag);
        check_counts(tag);
        check_maps(tag);
    endtask

    task automatic lookup(input int px, input int py, input logic exp_hi, input logic exp_lo, input string tag);
        x = 7'(px);
        y = 6'(py);
        @(negedge clk);
        tests_run++;
        if ({safe_h, safe_l} !== {exp_hi, exp_lo}) begin
            tests_failed++;
            $display("FAIL %s lookup(%0d,%0d): got %b expected %b", tag, px, py, {safe_h, safe_l}, {exp_hi, exp_lo});
        end
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        regen  = 1'b1;
        seed   = 16'h1234;
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        regen  = 1'b0;
        x = 7'd10;
        y = 6'd10;
        @(negedge clk);
        tests_run++;
        if ({busy_d, done_d, safe_d, cnt_d, busy_h, safe_h, cnt_h} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: got busy=%b done=%b safe=%b cnt=%0d hi_busy=%b hi_safe=%b hi_cnt=%0d expected all 0",
                     busy_d, done_d, safe_d, cnt_d, busy_h, safe_h, cnt_h);
        end
    endtask

    task automatic test_thresholds();
        run_gen(16'h1234, "gen_1234");
        tests_run++;
        if (cnt_h !== 4'd12) begin
            tests_failed++;
            $display("FAIL all256_count: got %0d expected 12", cnt_h);
        end
        lookup(79, 59, 1'b1, exp_l[N-1], "edge_pixel");
        lookup(80, 0, 1'b0, 1'b0, "col_out_of_range");
`ifdef SAFE_BORDER_EN
        tests_run++;
        if (cnt_l !== 4'd10) begin
            tests_failed++;
            $display("FAIL all0_border_count: got %0d expected 10", cnt_l);
        end
        lookup(30, 30, 1'b1, 1'b0, "interior_tile");
        lookup(0, 0, 1'b1, 1'b1, "corner_tile");
`else
        tests_run++;
        if (cnt_l !== 4'd0) begin
            tests_failed++;
            $display("FAIL all0_count: got %0d expected 0", cnt_l);
        end
        lookup(30, 30, 1'b1, 1'b0, "interior_tile");
        lookup(0, 0, 1'b1, 1'b0, "corner_tile");
`endif
    endtask

    task automatic test_determinism();
        logic [3:0] first_cnt;
        run_gen(16'hBEEF, "beef_a");
        first_cnt = cnt_d;
        run_gen(16'hBEEF, "beef_b");
        tests_run++;
        if (cnt_d !== first_cnt) begin
            tests_failed++;
            $display("FAIL beef_repeat_count: got %0d expected %0d", cnt_d, first_cnt);
        end
        run_gen(16'hACE1, "seed_ace1");
        first_cnt = cnt_d;
        run_gen(16'h0000, "seed_zero");
        tests_run++;
        if (cnt_d !== first_cnt) begin
            tests_failed++;
            $display("FAIL seed_zero_count: got %0d expected %0d", cnt_d, first_cnt);
        end
    endtask

    task automatic test_random_seeds();
        for (int i = 0; i < 4; i++) run_gen(16'($urandom), "random_seed");
    endtask

    task automatic test_restart();
        logic [15:0] s1, s2;
        s1 = 16'($urandom);
        s2 = 16'($urandom);
        set_expect(s2);
        pulse(s1);
        for (int k = 1; k <= 4; k++) @(negedge clk);
        pulse(s2);
        tests_run++;
        if (busy_d !== 1'b1) begin
            tests_failed++;
            $display("FAIL restart_busy: got %b expected 1", busy_d);
        end
        wait_done("restart");
        check_counts("restart");
        check_maps("restart");
    endtask

    task automatic test_busy_and_reset();
        int bad_safe = 0, bad_done = 0;
        x = 7'd30;
        y = 6'd30;
        pulse(16'($urandom));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (safe_h !== 1'b0) bad_safe++;
        end
        tests_run++;
        if (bad_safe !== 0) begin
            tests_failed++;
            $display("FAIL lookup_while_busy: got %0d nonzero lookups expected 0", bad_safe);
        end
        arst_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({busy_d, busy_h, busy_l, done_d, done_h, done_l} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_gen: got busy=%b%b%b done=%b%b%b expected all 0",
                     busy_d, busy_h, busy_l, done_d, done_h, done_l);
        end
        arst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (done_d || done_h || done_l || busy_d) bad_done++;
        end
        tests_run++;
        if (bad_done !== 0) begin
            tests_failed++;
            $display("FAIL no_done_after_reset: got %0d bad cycles expected 0", bad_done);
        end
        exp_d = '0;
        exp_h = '0;
        exp_l = '0;
        check_counts("after_reset");
        check_maps("after_reset");
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_thresholds();
        test_determinism();
        test_random_seeds();
        test_restart();
        test_busy_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
